// File: rtl/ex_alu_mc.sv
// Execute-stage ALU: logic, shift and arithmetic ops complete in one cycle;
// DIV/DIVU use a restoring divider and hold upstream until the quotient is ready.
module ex_alu_mc #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [7:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [WIDTH-1:0]  reg1_i,
  input  logic [WIDTH-1:0]  reg2_i,
  input  logic [ADDR_W-1:0] wd_i,
  input  logic              wreg_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [ADDR_W-1:0] wd_o,
  output logic              wreg_o,
  output logic [WIDTH-1:0]  wdata_o,
  output logic [WIDTH-1:0]  rem_o,
  output logic              stallreq_o
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int CNTW = $clog2(WIDTH + 1);
  localparam logic [CNTW-1:0] LAST_ITER = CNTW'(WIDTH - 1);

  localparam logic [7:0] OP_AND  = 8'b00100100;
  localparam logic [7:0] OP_OR   = 8'b00100101;
  localparam logic [7:0] OP_XOR  = 8'b00100110;
  localparam logic [7:0] OP_NOR  = 8'b00100111;
  localparam logic [7:0] OP_SLL  = 8'b01111100;
  localparam logic [7:0] OP_SRL  = 8'b00000010;
  localparam logic [7:0] OP_SRA  = 8'b00000011;
  localparam logic [7:0] OP_ADDU = 8'b00100001;
  localparam logic [7:0] OP_SUBU = 8'b00100011;
  localparam logic [7:0] OP_SLT  = 8'b00101010;
  localparam logic [7:0] OP_SLTU = 8'b00101011;
  localparam logic [7:0] OP_DIV  = 8'b00011010;
  localparam logic [7:0] OP_DIVU = 8'b00011011;

  localparam logic [2:0] SEL_LOGIC = 3'b001;
  localparam logic [2:0] SEL_SHIFT = 3'b010;
  localparam logic [2:0] SEL_ARITH = 3'b100;
  localparam logic [2:0] SEL_DIV   = 3'b110;

  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state_reg, state_next;

  logic              valid_reg;
  logic [ADDR_W-1:0] wd_reg;
  logic              wreg_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [WIDTH-1:0]  rem_reg;
  logic              stallreq;

  logic [CNTW-1:0]   cnt_reg;
  logic [WIDTH-1:0]  dvd_reg;
  logic [WIDTH-1:0]  dvs_reg;
  logic [WIDTH-1:0]  quo_reg;
  logic [WIDTH-1:0]  prem_reg;
  logic              q_neg_reg;
  logic              r_neg_reg;
  logic              dvs_zero_reg;
  logic [ADDR_W-1:0] div_wd_reg;
  logic              div_wreg_reg;

  logic [SHW-1:0]    shamt;
  logic [WIDTH-1:0]  alu_res;
  logic              is_div;
  logic              div_signed;
  logic [WIDTH-1:0]  dvd_mag;
  logic [WIDTH-1:0]  dvs_mag;
  logic [WIDTH:0]    shifted;
  logic [WIDTH:0]    trial;
  logic [WIDTH-1:0]  q_fin;
  logic [WIDTH-1:0]  r_fin;

  assign shamt      = reg1_i[SHW-1:0];
  assign is_div     = (alusel_i == SEL_DIV) && ((aluop_i == OP_DIV) || (aluop_i == OP_DIVU));
  assign div_signed = (aluop_i == OP_DIV);
  assign dvd_mag    = (div_signed && reg1_i[WIDTH-1]) ? -reg1_i : reg1_i;
  assign dvs_mag    = (div_signed && reg2_i[WIDTH-1]) ? -reg2_i : reg2_i;

  // One restoring step: bring down the next dividend bit, subtract if it fits.
  assign shifted = {prem_reg, quo_reg[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_reg};

  assign q_fin = dvs_zero_reg ? '1 : (q_neg_reg ? -quo_reg : quo_reg);
  assign r_fin = dvs_zero_reg ? dvd_reg : (r_neg_reg ? -prem_reg : prem_reg);

  always_comb begin
    alu_res = '0;
    case (alusel_i)
      SEL_LOGIC: begin
        case (aluop_i)
          OP_AND:  alu_res = reg1_i & reg2_i;
          OP_OR:   alu_res = reg1_i | reg2_i;
          OP_XOR:  alu_res = reg1_i ^ reg2_i;
          OP_NOR:  alu_res = ~(reg1_i | reg2_i);
          default: alu_res = '0;
        endcase
      end
      SEL_SHIFT: begin
        case (aluop_i)
          OP_SLL:  alu_res = reg2_i << shamt;
          OP_SRL:  alu_res = reg2_i >> shamt;
          OP_SRA:  alu_res = $unsigned($signed(reg2_i) >>> shamt);
          default: alu_res = '0;
        endcase
      end
      SEL_ARITH: begin
        case (aluop_i)
          OP_ADDU: alu_res = reg1_i + reg2_i;
          OP_SUBU: alu_res = reg1_i - reg2_i;
          OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
          OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (reg1_i < reg2_i)};
          default: alu_res = '0;
        endcase
      end
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    stallreq   = 1'b0;
    if (flush_i) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (valid_i && !stall_i && is_div) begin
            state_next = DIV;
            stallreq   = 1'b1;
          end
        end
        DIV: begin
          stallreq = 1'b1;
          if (cnt_reg == LAST_ITER) state_next = DONE;
        end
        DONE: begin
          if (!stall_i) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_reg    <= 1'b0;
      wd_reg       <= '0;
      wreg_reg     <= 1'b0;
      wdata_reg    <= '0;
      rem_reg      <= '0;
      cnt_reg      <= '0;
      dvd_reg      <= '0;
      dvs_reg      <= '0;
      quo_reg      <= '0;
      prem_reg     <= '0;
      q_neg_reg    <= 1'b0;
      r_neg_reg    <= 1'b0;
      dvs_zero_reg <= 1'b0;
      div_wd_reg   <= '0;
      div_wreg_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      if (!flush_i) begin
        case (state_reg)
          IDLE: begin
            if (valid_i && !stall_i) begin
              if (is_div) begin
                cnt_reg      <= '0;
                dvd_reg      <= reg1_i;
                dvs_reg      <= dvs_mag;
                quo_reg      <= dvd_mag;
                prem_reg     <= '0;
                q_neg_reg    <= div_signed && (reg1_i[WIDTH-1] ^ reg2_i[WIDTH-1]);
                r_neg_reg    <= div_signed && reg1_i[WIDTH-1];
                dvs_zero_reg <= (reg2_i == '0);
                div_wd_reg   <= wd_i;
                div_wreg_reg <= wreg_i;
              end else begin
                valid_reg <= 1'b1;
                wd_reg    <= wd_i;
                wreg_reg  <= wreg_i;
                wdata_reg <= alu_res;
                rem_reg   <= '0;
              end
            end
          end
          DIV: begin
            cnt_reg <= cnt_reg + 1'b1;
            if (!trial[WIDTH]) begin
              prem_reg <= trial[WIDTH-1:0];
              quo_reg  <= {quo_reg[WIDTH-2:0], 1'b1};
            end else begin
              prem_reg <= shifted[WIDTH-1:0];
              quo_reg  <= {quo_reg[WIDTH-2:0], 1'b0};
            end
          end
          DONE: begin
            if (!stall_i) begin
              valid_reg <= 1'b1;
              wd_reg    <= div_wd_reg;
              wreg_reg  <= div_wreg_reg;
              wdata_reg <= q_fin;
              rem_reg   <= r_fin;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Reset gates the request so an op held during reset never stalls upstream.
  assign stallreq_o = stallreq && !rst;
  assign valid_o    = valid_reg;
  assign wd_o       = wd_reg;
  assign wreg_o     = wreg_reg;
  assign wdata_o    = wdata_reg;
  assign rem_o      = rem_reg;

endmodule
